// File: rtl/dl_pkg.sv
// Shared helpers for the dl_* datapath blocks.
// occ_width keeps every consumer of an occupancy count sized identically.
package dl_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dl_dff_en_rst.sv
// WIDTH-bit register with asynchronous active-high reset to RST_VAL and a load enable.
module dl_dff_en_rst #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dl_pipe_reg.sv
// DEPTH-stage WIDTH-bit pipeline register with per-stage valid, stall, flush
// and an incrementally maintained occupancy count.
module dl_pipe_reg
  import dl_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              d,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              q,
  output logic [occ_width(DEPTH)-1:0]   occ
);

  localparam int OW = occ_width(DEPTH);

  // Handshake: a beat is accepted when in_valid=1 on an edge with en=1 and
  // flush=0; it is presented on q with out_valid=1 after DEPTH such edges.
  // There is no ready: the consumer must take every valid beat.
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             vld_en;

  // The valid chain must also load on a stalled flush so squashing is never lost.
  assign vld_en = en | flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] data_d;
    logic             vld_d;

    if (i == 0) begin : g_head
      assign data_d = d;
      assign vld_d  = in_valid & ~flush;
    end else begin : g_body
      assign data_d = data[i-1];
      assign vld_d  = vld[i-1] & ~flush;
    end

    dl_dff_en_rst #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_data (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (data_d),
      .q   (data[i])
    );

    dl_dff_en_rst #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
    ) u_vld (
      .clk (clk),
      .rst (rst),
      .en  (vld_en),
      .d   (vld_d),
      .q   (vld[i])
    );
  end

  // occ equals popcount(vld), so occ+1 only exceeds DEPTH transiently when the
  // last stage is leaving; modular arithmetic keeps the result exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + OW'(in_valid) - OW'(vld[DEPTH-1]);
    end
  end

  assign q         = data[DEPTH-1];
  assign out_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_dl_pipe_reg.sv
// Bench for dl_pipe_reg: directed vectors on a DEPTH=3 instance plus a
// random run shared by DEPTH=1/3/4/7 instances against per-instance queue models.
module tb_dl_pipe_reg;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } slot_t;

  typedef struct {
    logic       e;
    logic       f;
    logic       v;
    logic [7:0] d;
    logic [7:0] eq;
    logic       eov;
    logic [1:0] eocc;
  } vec_t;

  localparam int         DEP [4] = '{3, 1, 4, 7};
  localparam logic [7:0] RV  [4] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};

  logic       clk;
  logic       rst;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic [7:0] d;

  logic       ov3, ov1, ov4, ov7;
  logic [7:0] q3, q1, q4, q7;
  logic [1:0] occ3;
  logic [0:0] occ1;
  logic [2:0] occ4, occ7;

  logic       ov_a  [4];
  logic [7:0] q_a   [4];
  logic [3:0] occ_a [4];

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         chk_on   = 0;
  bit         adv      = 0;
  logic [7:0] exp_q [$];
  slot_t      mq [4][$];
  vec_t       tbl [23];

  dl_pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .out_valid(ov3), .q(q3), .occ(occ3));
  dl_pipe_reg #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .out_valid(ov1), .q(q1), .occ(occ1));
  dl_pipe_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .out_valid(ov4), .q(q4), .occ(occ4));
  dl_pipe_reg #(.WIDTH(8), .DEPTH(7), .RST_VAL(8'hFF)) u_d7 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .out_valid(ov7), .q(q7), .occ(occ7));

  assign ov_a[0] = ov3;  assign q_a[0] = q3;  assign occ_a[0] = {2'b0, occ3};
  assign ov_a[1] = ov1;  assign q_a[1] = q1;  assign occ_a[1] = {3'b0, occ1};
  assign ov_a[2] = ov4;  assign q_a[2] = q4;  assign occ_a[2] = {1'b0, occ4};
  assign ov_a[3] = ov7;  assign q_a[3] = q7;  assign occ_a[3] = {1'b0, occ7};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      for (int i = 0; i < DEP[k]; i++) mq[k].push_back({1'b0, RV[k]});
    end
  endtask

  // driver: called at a negedge, returns at the following negedge
  task automatic step(input logic e, input logic f, input logic v, input logic [7:0] dd);
    en       = e;
    flush    = f;
    in_valid = v;
    d        = dd;
    if (e && v && !f) exp_q.push_back(dd);
    @(posedge clk);
    @(negedge clk);
  endtask

  // model update on every edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
      adv = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (flush)
          for (int i = 0; i < mq[k].size(); i++) mq[k][i].v = 1'b0;
        if (en) begin
          void'(mq[k].pop_back());
          mq[k].push_front({in_valid & ~flush, d});
        end
      end
      if (flush) exp_q.delete();
      adv = en & ~flush;
    end
  end

  // scoreboard / model comparison away from the active edge
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      for (int k = 0; k < 4; k++) begin
        slot_t t;
        int    cnt;
        t   = mq[k][mq[k].size()-1];
        cnt = 0;
        for (int i = 0; i < mq[k].size(); i++) cnt += int'(mq[k][i].v);
        check($sformatf("d%0d_out_valid", DEP[k]), 32'(ov_a[k]), 32'(t.v));
        if (t.v) check($sformatf("d%0d_q", DEP[k]), 32'(q_a[k]), 32'(t.d));
        check($sformatf("d%0d_occ_popcount", DEP[k]), 32'(occ_a[k]), 32'(cnt));
      end
      if (adv && ov3) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 32'(q3), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("sb_q", 32'(q3), 32'(e));
        end
      end
      adv = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = '0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd1,  8'hA5, 1'b0, 2'd1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd2,  8'hA5, 1'b0, 2'd2};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'd3,  8'd1,  1'b1, 2'd3};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd4,  8'd2,  1'b1, 2'd3};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd3,  1'b1, 2'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd4,  1'b1, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 2'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'd10, 8'd0,  1'b0, 2'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd11, 8'd0,  1'b0, 2'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'd12, 8'd10, 1'b1, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd11, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd12, 1'b1, 2'd1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 2'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 8'd20, 8'd0,  1'b0, 2'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 8'd21, 8'd0,  1'b0, 2'd2};
    for (int i = 15; i < 20; i++)
      tbl[i] = '{1'b0, 1'b0, logic'(i % 2), 8'(i * 7), 8'd0, 1'b0, 2'd2};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 8'd5,  8'd20, 1'b1, 2'd2};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd21, 1'b1, 2'd1};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd5,  1'b0, 2'd0};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_d%0d_q", DEP[k]), 32'(q_a[k]), 32'(RV[k]));
      check($sformatf("rst_d%0d_out_valid", DEP[k]), 32'(ov_a[k]), 32'd0);
      check($sformatf("rst_d%0d_occ", DEP[k]), 32'(occ_a[k]), 32'd0);
    end
    rst    = 1'b0;
    chk_on = 1'b1;

    // streaming, bubbles and stall vectors
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_q", i), 32'(q3), 32'(tbl[i].eq));
      check($sformatf("tbl%0d_out_valid", i), 32'(ov3), 32'(tbl[i].eov));
      check($sformatf("tbl%0d_occ", i), 32'(occ3), 32'(tbl[i].eocc));
    end

    // flush with en=1, then with en=0; beat 99 must never emerge
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b0, 1'b1, 8'd7);
      step(1'b1, 1'b0, 1'b1, 8'd8);
      step(1'b1, 1'b0, 1'b1, 8'd9);
      check("flush_pre_occ", 32'(occ3), 32'd3);
      check("flush_pre_q", 32'(q3), 32'd7);
      step(logic'(pass == 0), 1'b1, 1'b1, 8'd99);
      check("flush_out_valid", 32'(ov3), 32'd0);
      check("flush_occ", 32'(occ3), 32'd0);
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("flush_drain_out_valid", 32'(ov3), 32'd0);
      end
    end

    // asynchronous reset mid-stream
    step(1'b1, 1'b0, 1'b1, 8'd31);
    step(1'b1, 1'b0, 1'b1, 8'd32);
    step(1'b1, 1'b0, 1'b1, 8'd33);
    check("mid_pre_occ", 32'(occ3), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q3), 32'hA5);
    check("mid_rst_out_valid", 32'(ov3), 32'd0);
    check("mid_rst_occ", 32'(occ3), 32'd0);
    check("mid_rst_d7_q", 32'(q7), 32'hFF);
    @(negedge clk);
    rst = 1'b0;

    // random traffic on all four depths
    repeat (10000) begin
      step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
